mem_bist_engine: RTL and testbench

//  Synthesizable built-in self-test engine sitting directly upstream of the 32x8 single-port memory.

---
 rtl/mem_bist_if.sv | 21 ++
 rtl/mem_bist_engine.sv | 172 +++++++++++++++++
 tb/tb_mem_bist_engine.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_if.sv
// Memory-side port of the BIST engine: strobes, address and write data out, read data back.
interface mem_bist_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output mem_write, mem_read, mem_addr, mem_data_in,
    input  mem_data_out
  );

  modport slave (
    input  mem_write, mem_read, mem_addr, mem_data_in,
    output mem_data_out
  );
endinterface

// File: rtl/mem_bist_engine.sv
// Three-pass memory BIST (clear, data=address, LFSR pattern) for a 2**ADDR_W x DATA_W
// single-port memory; reports pass/fail, a saturating error count and the first failure.
module mem_bist_engine #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] LFSR_SEED = 8'hA5,
  parameter int                ERR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail_valid,
  output logic [1:0]        fail_phase,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  mem_bist_if.master        mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_CHK  = 2'd3;

  localparam logic [1:0] PH_CLR = 2'd0;
  localparam logic [1:0] PH_ADR = 2'd1;
  localparam logic [1:0] PH_PAT = 2'd2;

  logic [1:0]        st, st_n;
  logic [1:0]        phase, phase_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] lfsr, lfsr_n;
  logic              wr_q, rd_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last;
  logic [DATA_W-1:0] exp_cur;
  logic              mismatch;
  logic [ERR_W-1:0]  err_n;
  logic              finish;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [DATA_W-1:0] exp_of(input logic [1:0]        ph,
                                               input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] l);
    case (ph)
      PH_CLR:  return '0;
      PH_ADR:  return DATA_W'(a);
      default: return l;
    endcase
  endfunction

  assign last     = (addr == {ADDR_W{1'b1}});
  assign exp_cur  = exp_of(phase, addr, lfsr);
  assign mismatch = (st == S_CHK) && (mem.mem_data_out != exp_cur);
  assign err_n    = (mismatch && (err_count != {ERR_W{1'b1}})) ? err_count + 1'b1 : err_count;
  assign finish   = (st == S_CHK) && last && (phase == PH_PAT);

  always_comb begin
    st_n    = st;
    phase_n = phase;
    addr_n  = addr;
    lfsr_n  = lfsr;
    case (st)
      S_IDLE: begin
        if (start) begin
          st_n    = S_WR;
          phase_n = PH_CLR;
          addr_n  = '0;
          lfsr_n  = LFSR_SEED;
        end
      end
      S_WR: begin
        if (phase == PH_PAT) lfsr_n = lfsr_step(lfsr);
        if (last) begin
          // read-back replays the same pattern from the seed
          st_n   = S_RD;
          addr_n = '0;
          lfsr_n = LFSR_SEED;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      S_RD: st_n = S_CHK;
      S_CHK: begin
        if (phase == PH_PAT) lfsr_n = lfsr_step(lfsr);
        if (!last) begin
          st_n   = S_RD;
          addr_n = addr + 1'b1;
        end else if (phase != PH_PAT) begin
          st_n    = S_WR;
          phase_n = phase + 2'd1;
          addr_n  = '0;
          lfsr_n  = LFSR_SEED;
        end else begin
          st_n   = S_IDLE;
          addr_n = '0;
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      phase      <= PH_CLR;
      addr       <= '0;
      lfsr       <= LFSR_SEED;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      wdata_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_phase <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
    end else begin
      st      <= st_n;
      phase   <= phase_n;
      addr    <= addr_n;
      lfsr    <= lfsr_n;
      // strobes and write data are registered against the state being entered
      wr_q    <= (st_n == S_WR);
      rd_q    <= (st_n == S_RD);
      wdata_q <= (st_n == S_WR) ? exp_of(phase_n, addr_n, lfsr_n) : '0;
      busy    <= (st_n != S_IDLE);

      if (st == S_IDLE && start) begin
        done       <= 1'b0;
        pass       <= 1'b0;
        err_count  <= '0;
        fail_valid <= 1'b0;
        fail_phase <= '0;
        fail_addr  <= '0;
        fail_exp   <= '0;
        fail_got   <= '0;
      end

      if (st == S_CHK) err_count <= err_n;

      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_phase <= phase;
        fail_addr  <= addr;
        fail_exp   <= exp_cur;
        fail_got   <= mem.mem_data_out;
      end

      if (finish) begin
        done <= 1'b1;
        pass <= (err_n == '0);
      end
    end
  end

  assign mem.mem_write   = wr_q;
  assign mem.mem_read    = rd_q;
  assign mem.mem_addr    = addr;
  assign mem.mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_bist_engine.sv
// Self-checking bench: behavioural 32x8 memory with injectable read faults, bus scoreboard,
// table of fault scenarios, reset/restart sequences and an ERR_W=4 saturation instance.
module tb_mem_bist_engine;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int RUN    = 3 * 3 * DEPTH;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start2;
  always #5 clk = ~clk;

  logic              busy, done, pass, fail_valid;
  logic [15:0]       err_count;
  logic [1:0]        fail_phase;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_exp, fail_got;

  logic              busy2, done2, pass2, fail_valid2;
  logic [3:0]        err_count2;
  logic [1:0]        fail_phase2;
  logic [ADDR_W-1:0] fail_addr2;
  logic [DATA_W-1:0] fail_exp2, fail_got2;

  mem_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif  ();
  mem_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif2 ();

  mem_bist_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LFSR_SEED(8'hA5), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_phase(fail_phase),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got), .mem(mif.master));

  mem_bist_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LFSR_SEED(8'hA5), .ERR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .fail_valid(fail_valid2), .fail_phase(fail_phase2),
    .fail_addr(fail_addr2), .fail_exp(fail_exp2), .fail_got(fail_got2), .mem(mif2.master));

  // fault modes: 0 ideal, 1 read bit0 stuck at 0, 2 bit0 flipped at addr 2 during pattern pass
  int          mode = 0;
  logic [7:0]  mem_arr [DEPTH];
  int          rd_cnt;

  always @(posedge clk) begin
    logic [7:0] d;
    if (mif.mem_write) mem_arr[mif.mem_addr] <= mif.mem_data_in;
    if (mif.mem_read) begin
      d = mem_arr[mif.mem_addr];
      if (mode == 1) d = d & 8'hFE;
      if (mode == 2 && rd_cnt >= 2 * DEPTH && mif.mem_addr == 5'd2) d = d ^ 8'h01;
      mif.mem_data_out <= d;
    end
    rd_cnt <= !busy ? 0 : rd_cnt + (mif.mem_read ? 1 : 0);
  end

  assign mif2.mem_data_out = 8'hFF;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // bus scoreboard: {write, read, addr, data_in} expected on every cycle of a run
  logic [31:0] sbq [$];
  logic [7:0]  pat [DEPTH];

  task automatic push_expected();
    for (int ph = 0; ph < 3; ph++) begin
      for (int a = 0; a < DEPTH; a++) begin
        logic [7:0] d;
        d = (ph == 0) ? 8'h00 : (ph == 1) ? 8'(a) : pat[a];
        sbq.push_back({17'd0, 1'b1, 1'b0, 5'(a), d});
      end
      for (int a = 0; a < DEPTH; a++) begin
        sbq.push_back({17'd0, 1'b0, 1'b1, 5'(a), 8'h00});
        sbq.push_back({17'd0, 1'b0, 1'b0, 5'(a), 8'h00});
      end
    end
  endtask

  task automatic bus_cmp();
    logic [31:0] e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("bus", {17'd0, mif.mem_write, mif.mem_read, mif.mem_addr, mif.mem_data_in}, e);
    end
  endtask

  // starts a run on dut, optionally re-pulses start mid-run or on the done edge,
  // and checks busy/cleared state after acceptance and the 288-cycle latency
  task automatic run(input bit sb, input int restart_at, input bit start_at_done);
    int lat;
    @(negedge clk) start = 1'b1;
    if (sb) push_expected();
    @(posedge clk); #1;
    chk("busy_after_start", busy, 1);
    chk("cleared_on_start", {done, pass, fail_valid, err_count}, 0);
    if (sb) bus_cmp();
    lat = -1;
    for (int n = 1; n <= RUN + 100; n++) begin
      @(negedge clk) start = (n == restart_at) || (start_at_done && n == RUN);
      @(posedge clk); #1;
      if (sb && n < RUN) bus_cmp();
      if (done) begin
        lat = n;
        break;
      end
    end
    @(negedge clk) start = 1'b0;
    chk("done_latency", lat, RUN);
    chk("idle_at_done", busy, 0);
    if (sb) chk("sb_leftover", sbq.size(), 0);
  endtask

  typedef struct {
    int         mode;
    logic       pass;
    bit         chk_err;
    logic [15:0] err;
    logic       fv;
    logic [1:0] ph;
    logic [4:0] addr;
    logic [7:0] exp;
    logic [7:0] got;
  } vec_t;

  vec_t vecs [3];

  initial begin
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < DEPTH; i++) begin
      pat[i] = l;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    vecs[0] = '{1, 1'b0, 1'b0, 16'd0, 1'b1, 2'd1, 5'd1, 8'h01, 8'h00};
    vecs[1] = '{2, 1'b0, 1'b1, 16'd1, 1'b1, 2'd2, 5'd2, 8'h95, 8'h94};
    vecs[2] = '{0, 1'b1, 1'b1, 16'd0, 1'b0, 2'd0, 5'd0, 8'h00, 8'h00};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", {busy, done, pass, fail_valid, err_count}, 0);
    chk("reset_bus", {mif.mem_write, mif.mem_read, mif.mem_addr, mif.mem_data_in}, 0);
    chk("reset_status2", {busy2, done2, err_count2}, 0);
    @(negedge clk) rst_n = 1'b1;

    // ideal memory with full bus scoreboard
    mode = 0;
    run(1'b1, 0, 1'b0);
    chk("ideal_result", {pass, fail_valid, err_count}, {1'b1, 1'b0, 16'd0});

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      run(1'b0, 0, 1'b0);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].pass);
      if (vecs[i].chk_err) chk($sformatf("v%0d_err", i), err_count, vecs[i].err);
      chk($sformatf("v%0d_record", i), {fail_valid, fail_phase, fail_addr, fail_exp, fail_got},
          {vecs[i].fv, vecs[i].ph, vecs[i].addr, vecs[i].exp, vecs[i].got});
    end

    // mid-run reset at cycle 100
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (99) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_state", {busy, done, mif.mem_write, mif.mem_read}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_quiet", {mif.mem_write, mif.mem_read}, 0);
    @(negedge clk) rst_n = 1'b1;
    run(1'b0, 0, 1'b0);
    chk("after_reset_pass", pass, 1);

    // start during a run and on the done edge are ignored
    mode = 2;
    run(1'b0, 50, 1'b1);
    chk("restart_ignored_err", err_count, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_sticky", {done, busy}, 2'b10);
    mode = 0;
    run(1'b0, 0, 1'b0);
    chk("second_run_pass", {pass, fail_valid, err_count}, {1'b1, 1'b0, 16'd0});

    // ERR_W=4 instance against an all-ones memory
    begin
      int lat2;
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      lat2 = -1;
      for (int n = 1; n <= RUN + 100; n++) begin
        @(posedge clk); #1;
        if (done2) begin
          lat2 = n;
          break;
        end
      end
      chk("sat_latency", lat2, RUN);
      chk("sat_count", {pass2, err_count2}, {1'b0, 4'hF});
      chk("sat_record", {fail_valid2, fail_phase2, fail_addr2, fail_exp2, fail_got2},
          {1'b1, 2'd0, 5'd0, 8'h00, 8'hFF});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
